// File: rtl/adder_rr_arbiter.sv
// Two-requester round-robin front end for one shared WIDTH-bit ripple adder.
// One transaction in flight: accept (IDLE), add (CALC), hold result until taken (RESP).
module adder_rr_arbiter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_v,
    output logic             busy,
    output logic             grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                    last;
    logic                    grant_r;
    logic                    pick;
    logic                    accept;
    logic                    rsp_take;
    logic signed [WIDTH-1:0] a_p0;
    logic signed [WIDTH-1:0] b_p0;
    logic        [WIDTH:0]   sum_p0;

    function automatic logic [WIDTH:0] ripple_add(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic             c;
        logic [WIDTH-1:0] s;
        c = 1'b0;
        s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return {c, s};
    endfunction

    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Only one valid wins outright; on a tie the requester not served last wins.
    always_comb begin
        pick       = (req0_valid && req1_valid) ? ~last : req1_valid;
        accept     = (state == IDLE) && (req0_valid || req1_valid) && !rst;
        req0_ready = accept && !pick;
        req1_ready = accept && pick;
        rsp_take   = grant_r ? rsp1_ready : rsp0_ready;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0_valid || req1_valid) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (rsp_take) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            grant_r  <= 1'b0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_v    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last    <= pick;
                grant_r <= pick;
            end
            if (state == CALC) begin
                rsp_sum  <= sum_p0[WIDTH-1:0];
                rsp_cout <= sum_p0[WIDTH];
                rsp_v    <= signed_ovf(a_p0[WIDTH-1], b_p0[WIDTH-1], sum_p0[WIDTH-1]);
            end
        end
    end

    // Stage 0: granted operands, captured on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0 <= pick ? req1_a : req0_a;
            b_p0 <= pick ? req1_b : req0_b;
        end
    end

    // Stage 1: sum formed from stage-0 operands during CALC
    assign sum_p0 = ripple_add(a_p0, b_p0);

    assign rsp0_valid = (state == RESP) && !grant_r;
    assign rsp1_valid = (state == RESP) && grant_r;
    assign busy       = (state != IDLE);
    assign grant_id   = (state == IDLE) ? (pick && !rst) : grant_r;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Scoreboard bench for adder_rr_arbiter: directed operand vectors with
// hand-computed responses; a monitor pops and compares on each response handshake.
module tb_adder_rr_arbiter;

    localparam int WIDTH = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a = '0;
    logic [WIDTH-1:0] req0_b = '0;
    logic             req1_valid = 1'b0;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a = '0;
    logic [WIDTH-1:0] req1_b = '0;
    logic             rsp0_valid;
    logic             rsp0_ready = 1'b0;
    logic             rsp1_valid;
    logic             rsp1_ready = 1'b0;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
    logic             rsp_v;
    logic             busy;
    logic             grant_id;

    adder_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_v(rsp_v),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit id;
        int sum;
        int cout;
        int v;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_rsp(input bit id, input int s, input int c, input int v);
        exp_t e;
        e.id = id; e.sum = s; e.cout = c; e.v = v;
        expq.push_back(e);
    endtask

    // Monitor: one channel at a time, pop on every response handshake
    always @(negedge clk) begin
        if (!rst) begin
            chk("rsp_onehot", int'(rsp0_valid & rsp1_valid), 0);
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got response on channel %0d, expected none", rsp1_valid);
                end else begin
                    mon_e = expq.pop_front();
                    chk("rsp_id", int'(rsp1_valid), int'(mon_e.id));
                    chk("rsp_sum", int'(rsp_sum), mon_e.sum);
                    chk("rsp_cout", int'(rsp_cout), mon_e.cout);
                    chk("rsp_v", int'(rsp_v), mon_e.v);
                end
            end
        end
    end

    // Present operands from posedge+1 until accepted; returns at posedge+1 after accept.
    task automatic send(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output int acc);
        bit done;
        done = 1'b0;
        acc  = -1;
        if (id) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                done = 1'b1;
                acc  = cyc;
                chk("grant_id_at_accept", int'(grant_id), int'(id));
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: requester %0d got no ready, expected ready within 40 cycles", id);
        end
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && expq.size() != 0; n++) @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ta, tb, t0a, t0b, t1a, t1b, k;
        int s0, s1, s2, s3;

        // Reset values, with a request held during reset
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 5'd3; req0_b = 5'd4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req0_ready", int'(req0_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp0_valid", int'(rsp0_valid), 0);
        chk("rst_rsp1_valid", int'(rsp1_valid), 0);
        chk("rst_rsp_sum", int'(rsp_sum), 0);
        chk("rst_rsp_cout", int'(rsp_cout), 0);
        chk("rst_rsp_v", int'(rsp_v), 0);
        chk("rst_grant_id", int'(grant_id), 0);
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single op on requester 0 with timing of busy/valid
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        expect_rsp(0, 7, 0, 0);
        send(0, 5'd3, 5'd4, ta);
        @(negedge clk);
        chk("single_calc_busy", int'(busy), 1);
        chk("single_calc_rsp0_valid", int'(rsp0_valid), 0);
        @(negedge clk);
        chk("single_resp_rsp0_valid", int'(rsp0_valid), 1);
        chk("single_resp_rsp1_valid", int'(rsp1_valid), 0);
        chk("single_resp_busy", int'(busy), 1);
        chk("single_resp_cycle", cyc - ta, 2);
        @(negedge clk);
        chk("single_after_rsp0_valid", int'(rsp0_valid), 0);
        chk("single_after_busy", int'(busy), 0);
        drain();

        // Overflow / carry corner cases on requester 1
        expect_rsp(1, 16, 0, 1);
        send(1, 5'b01111, 5'b00001, ta);
        expect_rsp(1, 0, 1, 1);
        send(1, 5'b10000, 5'b10000, ta);
        expect_rsp(1, 0, 1, 0);
        send(1, 5'b11111, 5'b00001, ta);
        drain();

        // Round robin with both requesters valid continuously from reset
        pulse_reset();
        expect_rsp(0, 3, 0, 0);
        expect_rsp(1, 7, 0, 0);
        expect_rsp(0, 11, 0, 0);
        expect_rsp(1, 15, 0, 0);
        fork
            begin send(0, 5'd1, 5'd2, t0a); send(0, 5'd5, 5'd6, t0b); end
            begin send(1, 5'd3, 5'd4, t1a); send(1, 5'd7, 5'd8, t1b); end
        join
        chk("rr_gap_0a_1a", t1a - t0a, 3);
        chk("rr_gap_1a_0b", t0b - t1a, 3);
        chk("rr_gap_0b_1b", t1b - t0b, 3);
        drain();

        // Backpressure on response 0 while requester 1 waits
        rsp0_ready = 1'b0;
        k = -1;
        expect_rsp(0, 4, 0, 0);
        expect_rsp(1, 18, 0, 1);
        fork
            send(0, 5'd2, 5'd2, ta);
            send(1, 5'd9, 5'd9, tb);
            begin
                bit seen;
                seen = 1'b0;
                for (int n = 0; n < 20 && !seen; n++) begin
                    @(negedge clk);
                    seen = rsp0_valid;
                end
                chk("bp_rsp0_seen", int'(seen), 1);
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("bp_rsp0_valid", int'(rsp0_valid), 1);
                    chk("bp_rsp_sum", int'(rsp_sum), 4);
                    chk("bp_req1_ready", int'(req1_ready), 0);
                end
                @(posedge clk);
                #1;
                rsp0_ready = 1'b1;
                k = cyc;
            end
        join
        chk("bp_req1_accept_next", tb, k + 1);
        drain();

        // Reset asserted during CALC drops the transaction
        send(0, 5'd1, 5'd1, ta);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_rsp0_valid", int'(rsp0_valid), 0);
        chk("midrst_rsp1_valid", int'(rsp1_valid), 0);
        chk("midrst_rsp_sum", int'(rsp_sum), 0);
        chk("midrst_rsp_cout", int'(rsp_cout), 0);
        chk("midrst_rsp_v", int'(rsp_v), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_grant_id", int'(grant_id), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_rsp(0, 9, 0, 0);
        expect_rsp(1, 13, 0, 0);
        fork
            send(0, 5'd4, 5'd5, ta);
            send(1, 5'd6, 5'd7, tb);
        join
        chk("midrst_order_gap", tb - ta, 3);
        drain();

        // Requester 1 alone for four back-to-back ops
        expect_rsp(1, 2, 0, 0);
        expect_rsp(1, 5, 0, 0);
        expect_rsp(1, 20, 0, 1);
        expect_rsp(1, 1, 1, 0);
        send(1, 5'd1, 5'd1, s0);
        send(1, 5'd2, 5'd3, s1);
        send(1, 5'd10, 5'd10, s2);
        send(1, 5'd30, 5'd3, s3);
        chk("streak_gap1", s1 - s0, 3);
        chk("streak_gap2", s2 - s1, 3);
        chk("streak_gap3", s3 - s2, 3);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
Shares one WIDTH-bit two's-complement ripple adder, with carry-out and signed-overflow outputs, between two requesters. The block arbitrates round-robin, registers the granted operands and computes the sum in one cycle. It then holds the registered result on the winner's response channel until that requester accepts it. It sits between the operand producers and the shared arithmetic resource; there is one transaction in flight at a time.

Parameters:
WIDTH, 5, operand/sum width in bits (fixed requester count = 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 presents operands
req0_ready  output  1  requester 0 operands accepted this cycle
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req1_valid  input  1  requester 1 presents operands
req1_ready  output  1  requester 1 operands accepted this cycle
req1_a  input  WIDTH  requester 1 operand A
req1_b  input  WIDTH  requester 1 operand B
rsp0_valid  output  1  result for requester 0 available
rsp0_ready  input  1  requester 0 takes result
rsp1_valid  output  1  result for requester 1 available
rsp1_ready  input  1  requester 1 takes result
rsp_sum  output  WIDTH  registered sum (shared by both response channels)
rsp_cout  output  1  registered carry-out of MSB
rsp_v  output  1  registered signed overflow
busy  output  1  high in any state other than IDLE
grant_id  output  1  requester owning the current transaction

Behaviour:
- FSM states and transitions:
  - IDLE: on any reqN_valid, grant and accept, latch a/b, go to CALC. Stay in IDLE if no valid.
  - CALC: compute a+b with carry-in 0, register sum/cout/v, go to RESP. CALC always lasts exactly 1 cycle.
  - RESP: rspN_valid=1 for the granted N only. On rspN_ready=1, go to IDLE.
- Ready rule: reqN_ready = (state==IDLE) && grant==N && reqN_valid && !rst. This is combinational; it does not depend on rsp ports. Accept = valid && ready in the same cycle.
- Latency: accept at cycle T, CALC at T+1, rspN_valid first high at T+2. Minimum spacing between accepts is 3 cycles; a response handshake at cycle R allows the next accept at R+1.
- Arbitration:
  - Register `last` (1 bit) holds the most recently granted requester.
  - Only one valid: that requester wins regardless of `last`.
  - Both valid: the requester != last wins.
  - `last` updates on accept only.
- Arithmetic:
  - sum = (a+b) mod 2^WIDTH.
  - cout = bit WIDTH of the unsigned sum.
  - v = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
- Response hold: rsp_sum/cout/v and rspN_valid stay stable until the handshake. Requesters must hold valid/a/b until ready. rspN_ready asserted early (before valid) is legal; the handshake then completes in the first RESP cycle.
- grant_id is registered at accept and holds through CALC/RESP. In IDLE it shows the combinational arbitration choice, or 0 if there are no requests.
- Reset values (rst high at an edge, any state, including mid-transaction):
  - state=IDLE, last=1 (so requester 0 wins the first tie).
  - rsp_sum=0, rsp_cout=0, rsp_v=0; rsp0_valid=rsp1_valid=0; busy=0; grant_id=0.
  - The in-flight transaction is dropped with no response; req ready outputs are 0 while rst is high.
- A requester deasserting valid in IDLE with no accept is ignored; there is no state change.

Test Plan:
- Single op: req0_valid, a=3, b=4, rsp0_ready=1 -> req0_ready at T; rsp0_valid at T+2 for 1 cycle, sum=7, cout=0, v=0; rsp1_valid stays 0; busy high T+1..T+2.
- Overflow: req1 a=5'b01111, b=5'b00001 -> sum=5'b10000, cout=0, v=1. Then a=5'b10000, b=5'b10000 -> sum=0, cout=1, v=1. Then a=5'b11111, b=5'b00001 -> sum=0, cout=1, v=0.
- Round-robin: both valid continuously from reset, rsp ready tied 1 -> grant order 0,1,0,1; accepts every 3 cycles; each response carries that requester's own operands.
- Backpressure: req0 accepted, rsp0_ready low 5 cycles with req1_valid high -> rsp0_valid and sum stable all 5 cycles, req1_ready=0. On rsp0_ready=1, req1 is accepted the next cycle.
- Reset mid-op: assert rst during CALC -> next cycle all rsp valids 0 and outputs zero. After release with both valid, requester 0 is granted first.
- Single-requester streak: only req1 valid for 4 ops -> req1 granted each time with no idle gaps beyond the 3-cycle cadence.
